// File: rtl/mod_mem_access_unit.sv
`default_nettype none
//==============================================================================
// Module      : mod_mem_access_unit
// Description : Load/store unit. Runs one external bus transaction at a time,
//               with byte lanes, sign/zero extension, misalignment and timeout.
// Revision    : 1.0 - initial release
//==============================================================================
module mod_mem_access_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] ext_mem_data,
  output logic        misalign,
  output logic        timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_last_wait = 8'(MAX_WAIT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_unsigned;
  logic        r_is_load;

  logic        w_req;
  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load_val;

  assign w_req = mem_read | mem_write;

  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = store_data;
    case (size)
      2'b00: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_legal = ~addr[0];
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        w_legal = (addr[1:0] == 2'b00);
        w_be    = 4'b1111;
        w_wdata = store_data;
      end
      default: begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = store_data;
      end
    endcase
  end

  // Word loads are always aligned, so the shifted lane is the full word there.
  assign w_lane = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_val = w_lane;
    case (r_size)
      2'b00:   w_load_val = r_unsigned ? {24'd0, w_lane[7:0]}
                                       : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load_val = r_unsigned ? {16'd0, w_lane[15:0]}
                                       : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_load_val = w_lane;
    endcase
  end

  // Gated by rst_n so every output reads zero while reset is held.
  assign stall = rst_n & (((r_state == IDLE) & w_req & w_legal) | (r_state == BUSY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_unsigned   <= 1'b0;
      r_is_load    <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_be       <= 4'd0;
      bus_wdata    <= 32'd0;
      ext_mem_data <= 32'd0;
      misalign     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      misalign <= 1'b0;
      timeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req && !w_legal) begin
            misalign <= 1'b1;
          end else if (w_req) begin
            r_state    <= BUSY;
            r_cnt      <= 8'd0;
            r_size     <= size;
            r_off      <= addr[1:0];
            r_unsigned <= load_unsigned;
            r_is_load  <= ~mem_write;
            bus_req    <= 1'b1;
            bus_we     <= mem_write;
            bus_addr   <= {addr[31:2], 2'b00};
            bus_be     <= w_be;
            bus_wdata  <= w_wdata;
          end
        end
        BUSY: begin
          // An ack on the final wait cycle still wins over the timeout.
          if (bus_ack) begin
            r_state <= DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= 4'd0;
            if (r_is_load) ext_mem_data <= w_load_val;
          end else if (r_cnt == c_last_wait) begin
            r_state <= DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= 4'd0;
            timeout <= 1'b1;
            if (r_is_load) ext_mem_data <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
